uart_frame_host: RTL
====================

// Module: uart_frame_host
// PURPOSE
//  Client side of the UART byte interface (rx_rdy/clr_rx_rdy/rx_data, trmt/tx_data/tx_done).
//  Hunts for a sync byte, then streams NUM_PIX pixel bytes from the PC into the image RAM.
//  Pulses img_done, waits for the CNN result, and returns a 2-byte reply to the PC.
//  Sits between the UART and the image buffer / classifier in the de0-nano top level.
// PARAMETERS
//  NUM_PIX    784          pixel bytes per frame (28x28)
//  ADDR_W     10           image RAM address width; 2**ADDR_W >= NUM_PIX
//  SYNC_BYTE  8'hAA        frame start marker
//  RESP_HDR   8'h55        first byte of the reply
//  TIMEOUT    5_000_000    idle clk cycles allowed between bytes in LOAD (>=1)
// PORTS
//  clk        in   1       system clock (50 MHz)
//  rst_n      in   1       asynchronous reset, active-low
//  rx_rdy     in   1       UART byte available
//  rx_data    in   8       UART received byte
//  clr_rx_rdy out  1       1-cycle pulse: byte consumed
//  trmt       out  1       1-cycle pulse: start UART transmit of tx_data
//  tx_data    out  8       byte to transmit; stable from trmt until tx_done
//  tx_done    in   1       UART transmit complete (cleared by UART on trmt)
//  img_we     out  1       image RAM write strobe
//  img_addr   out  ADDR_W  image RAM write address
//  img_wdata  out  8       image RAM write data
//  img_done   out  1       1-cycle pulse: full frame written
//  res_vld    in   1       classifier result valid (pulse or level)
//  res_class  in   4       classifier result, 0..9
//  busy       out  1       high in every state except IDLE
//  frm_err    out  1       1-cycle pulse: LOAD timed out
// BEHAVIOUR
//  Reset: all outputs 0, tx_data 0, img_addr 0; state IDLE; all counters 0.
//  Byte accept: accept when rx_rdy && !clr_rx_rdy, so a byte is never taken twice.
//   - clr_rx_rdy is asserted in the accept cycle; the byte is sampled in that cycle.
//   - Bytes are accepted and discarded in every state except LOAD and IDLE.
//  States:
//   - IDLE: accepted byte == SYNC_BYTE -> LOAD, pix_cnt=0. Any other byte is dropped.
//   - LOAD, on each accepted byte:
//     img_we=1, img_addr=pix_cnt, img_wdata=byte, all registered (1 cycle after accept);
//     pix_cnt++.
//     After write index NUM_PIX-1: img_done pulses the cycle after that img_we -> WAIT_RES.
//     A SYNC_BYTE value inside LOAD is pixel data, not a restart.
//   - LOAD timeout: idle counter resets on every accept. At TIMEOUT cycles: frm_err pulse,
//     -> IDLE, no img_done. Partially written RAM is left as is.
//   - WAIT_RES: res_vld=1 latches res_class. Then tx_data=RESP_HDR, trmt pulse -> TX_HDR.
//     res_vld outside WAIT_RES is ignored.
//   - TX_HDR: skip the trmt cycle and the cycle after it (stale tx_done). Then wait tx_done=1.
//     Then tx_data={4'h0,class}, trmt pulse -> TX_CLS.
//   - TX_CLS: same tx_done rule; on tx_done -> IDLE.
//  trmt is never reasserted before tx_done for the previous byte.
//  Counters: pix_cnt is ADDR_W bits and saturates conceptually at NUM_PIX (never wraps).
//   Idle counter is $clog2(TIMEOUT+1) bits.
//  rst_n low mid-frame or mid-transmit: immediate return to IDLE with reset values.
//   No partial reply is completed after reset.
// TESTING
//  1. 0xAA, then bytes 0..783 mod 256 -> 784 img_we at addr 0..783 with matching data.
//     img_done pulses once; busy stays high.
//  2. Bytes 0x12,0x34 before 0xAA -> no img_we.
//     0xAA inside pixel data is written as data at its index.
//  3. LOAD, stop after 100 bytes, TIMEOUT=1000 in bench -> frm_err at cycle 1000, IDLE,
//     no img_done.
//  4. After img_done, res_vld with res_class=7 -> UART serializes 0x55, then 0x07.
//     Exactly 2 trmt pulses; second trmt only after first tx_done.
//  5. rx_rdy held across 2 cycles for one byte -> exactly one clr_rx_rdy, one img_we.
//  6. rst_n asserted at pixel 400, then a new full frame -> addr restarts at 0.
//     All outputs 0 during reset; correct img_done.

Source files
------------

// File: rtl/uart_frame_host.sv
// Frame host between the UART byte interface and the image RAM / classifier.
// Hunts for a sync byte, loads one frame of pixels, then returns a 2-byte reply.
module uart_frame_host #(
  parameter int             NUM_PIX   = 784,
  parameter int             ADDR_W    = 10,
  parameter logic [7:0]     SYNC_BYTE = 8'hAA,
  parameter logic [7:0]     RESP_HDR  = 8'h55,
  parameter int             TIMEOUT   = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              img_done,
  input  logic              res_vld,
  input  logic [3:0]        res_class,
  output logic              busy,
  output logic              frm_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RES, TX_HDR, TX_CLS} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [3:0]        cls;
  logic [1:0]        skip;
  logic              done_pend;
  logic              accept;

  // A byte still showing rx_rdy while we are clearing it has already been taken.
  assign accept = rx_rdy && !clr_rx_rdy;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      idle_cnt   <= '0;
      cls        <= '0;
      skip       <= '0;
      done_pend  <= 1'b0;
      clr_rx_rdy <= 1'b0;
      trmt       <= 1'b0;
      tx_data    <= '0;
      img_we     <= 1'b0;
      img_addr   <= '0;
      img_wdata  <= '0;
      img_done   <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      clr_rx_rdy <= accept;
      img_we     <= 1'b0;
      trmt       <= 1'b0;
      frm_err    <= 1'b0;
      done_pend  <= 1'b0;
      img_done   <= done_pend;
      case (state)
        IDLE: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state    <= LOAD;
            pix_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            img_we    <= 1'b1;
            img_addr  <= pix_cnt;
            img_wdata <= rx_data;
            idle_cnt  <= '0;
            if (pix_cnt == PIX_LAST) begin
              done_pend <= 1'b1;
              state     <= WAIT_RES;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            frm_err <= 1'b1;
            state   <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        WAIT_RES: begin
          if (res_vld) begin
            cls     <= res_class;
            tx_data <= RESP_HDR;
            trmt    <= 1'b1;
            skip    <= 2'd2;
            state   <= TX_HDR;
          end
        end
        // tx_done is stale for the trmt cycle and the one after it.
        TX_HDR: begin
          if (skip != 2'd0) begin
            skip <= skip - 1'b1;
          end else if (tx_done) begin
            tx_data <= {4'h0, cls};
            trmt    <= 1'b1;
            skip    <= 2'd2;
            state   <= TX_CLS;
          end
        end
        TX_CLS: begin
          if (skip != 2'd0) begin
            skip <= skip - 1'b1;
          end else if (tx_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
